frame_capture_ctrl: RTL and testbench
=====================================

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 768: image width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 512: image height in pixels.
REQ-003 SHALL have parameter PIX_W, default 8: bits per channel.
REQ-004 SHALL have parameter CHANNELS, default 3: channels per pixel, packed with channel 0 in the LSBs (R=0, G=1, B=2).
REQ-005 SHALL have parameter COORD_W, default 11: coordinate width.
REQ-006 SHALL have parameter CONTINUOUS, default 0: when 1, re-arm automatically after each frame.
REQ-007 SHALL have port CAMERA_CLK, in, 1: clock; all logic is on the rising edge.
REQ-008 SHALL have port rst, in, 1: reset, synchronous, active-high.
REQ-009 SHALL have port start, in, 1: single-cycle pulse that arms a capture.
REQ-010 SHALL have ports in_valid, in, 1; in_pix, in, CHANNELS*PIX_W; in_x, in_y, in, COORD_W each: camera pixel stream with coordinates.
REQ-011 SHALL have ports out_valid, out, 1; out_ready, in, 1; out_pix, out, STORE_W; out_x, out_y, out, COORD_W each: readout stream.
REQ-012 SHALL have outputs write_done, read_done, busy and err_oob, 1 bit each.
REQ-013 SHALL have output frame_count, 16 bits.

Function
REQ-014 SHALL hold an internal buffer of WIDTH*HEIGHT words of width STORE_W, with address = y*WIDTH + x.
REQ-015 SHALL implement states IDLE, ARM, CAPTURE, READOUT and DONE.
REQ-016 SHALL change state as follows:
- IDLE or DONE with start goes to ARM.
- ARM with in_valid at (0,0) goes to CAPTURE, and that pixel is written.
- CAPTURE goes to READOUT once the pixel at (WIDTH-1,HEIGHT-1) is written.
- READOUT goes to DONE once the last pixel is accepted.
- DONE with CONTINUOUS=1 goes to ARM on the next cycle.
REQ-017 SHALL, in CAPTURE, write every in_valid pixel whose coordinates are in range; there is no backpressure on the input.
REQ-018 SHALL drop any in_valid pixel with x>=WIDTH or y>=HEIGHT and set err_oob sticky until the next start or rst.
REQ-019 SHALL ignore in_valid in IDLE, DONE and READOUT, and in ARM at any coordinate other than (0,0).
REQ-020 SHALL assert write_done on the cycle after the last pixel is written, and hold it until the next start or rst.
REQ-021 SHALL, in READOUT, stream addresses 0 through WIDTH*HEIGHT-1 in raster order, with out_x and out_y matching each pixel.
REQ-022 SHALL assert the first out_valid exactly 2 cycles after entering READOUT, allowing for synchronous-read RAM.
REQ-023 SHALL advance the readout only on out_valid && out_ready.
REQ-024 SHALL keep out_pix, out_x and out_y stable while out_valid && !out_ready.
REQ-025 SHALL, on acceptance of the last pixel, deassert out_valid, assert read_done (held until the next start or rst) and increment frame_count, wrapping from 0xFFFF to 0.
REQ-026 SHALL drive busy = 1 in ARM, CAPTURE and READOUT, and 0 otherwise.
REQ-027 SHALL ignore start in ARM, CAPTURE and READOUT.
REQ-028 SHALL, on start in DONE, clear write_done, read_done and err_oob and go to ARM on the same edge.
REQ-029 SHALL give rst priority over start and in_valid when they occur in the same cycle.

Reset
REQ-030 SHALL, on rst, set state to IDLE and every output to 0, including out_pix, out_x, out_y and frame_count.
REQ-031 SHALL abort any capture or readout in progress on rst; buffer contents need not be cleared.
REQ-032 SHALL, after rst, require a new start before any pixel is written.

Configuration
REQ-033 SHALL use macro FRAME_CAPTURE_GRAY_EN to select the stored format.
REQ-034 SHALL, with FRAME_CAPTURE_GRAY_EN defined, store STORE_W=PIX_W with gray = (ch0 + 2*ch1 + ch2) >> 2, computed at PIX_W+2 bits with truncating shift; this requires CHANNELS=3.
REQ-035 SHALL, without FRAME_CAPTURE_GRAY_EN, store STORE_W = CHANNELS*PIX_W with the input word unchanged.
REQ-036 SHALL keep interface timing and latency identical in both configurations.

Verification
REQ-037 SHALL cover a full frame: WIDTH=4, HEIGHT=2, start, then 8 raster pixels in_pix=0x000000+i with out_ready=1. Required: write_done 1 cycle after (3,1); out_valid 2 cycles into READOUT; out_pix sequence 0..7 with matching x/y; read_done=1; frame_count=1.
REQ-038 SHALL cover backpressure: out_ready toggled 1,0,0,1,... during readout. Required: no pixel lost or duplicated, and out_pix held stable while stalled.
REQ-039 SHALL cover out-of-bounds input: pixel at (5,0) injected mid-capture with WIDTH=4. Required: err_oob=1, buffer unchanged, and the frame still completes.
REQ-040 SHALL cover arming: in_valid at (2,0) while in ARM. Required: ignored and state stays ARM; the subsequent (0,0) enters CAPTURE.
REQ-041 SHALL cover reset mid-operation: rst asserted during READOUT. Required: next cycle all outputs 0, state IDLE, frame_count 0, and a fresh start captures correctly.
REQ-042 SHALL cover the gray format: with FRAME_CAPTURE_GRAY_EN, in_pix with ch0=0x10, ch1=0x20, ch2=0x30. Required: out_pix=0x20; with ch0=ch1=ch2=0xFF, required out_pix=0xFF.

Source files
------------

// File: rtl/frame_capture_ctrl_if.sv
// Camera pixel stream and buffered readout stream for frame_capture_ctrl.
// The stored word width follows FRAME_CAPTURE_GRAY_EN, the same as in the controller.
interface frame_capture_ctrl_if #(
    parameter int PIX_W    = 8,
    parameter int CHANNELS = 3,
    parameter int COORD_W  = 11
);
`ifdef FRAME_CAPTURE_GRAY_EN
    localparam int STORE_W = PIX_W;
`else
    localparam int STORE_W = CHANNELS * PIX_W;
`endif

    logic                         in_valid;
    logic [CHANNELS*PIX_W-1:0]    in_pix;
    logic [COORD_W-1:0]           in_x;
    logic [COORD_W-1:0]           in_y;

    logic                         out_valid;
    logic                         out_ready;
    logic [STORE_W-1:0]           out_pix;
    logic [COORD_W-1:0]           out_x;
    logic [COORD_W-1:0]           out_y;

    modport master (
        output in_valid, in_pix, in_x, in_y, out_ready,
        input  out_valid, out_pix, out_x, out_y
    );

    modport slave (
        input  in_valid, in_pix, in_x, in_y, out_ready,
        output out_valid, out_pix, out_x, out_y
    );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Captures one camera frame into an on-chip buffer, then streams it back out in raster order.
// Define FRAME_CAPTURE_GRAY_EN to store 8-bit luma instead of the raw multi-channel word.
module frame_capture_ctrl #(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int PIX_W      = 8,
    parameter int CHANNELS   = 3,
    parameter int COORD_W    = 11,
    parameter int CONTINUOUS = 0
) (
    input  logic                  CAMERA_CLK,
    input  logic                  rst,
    input  logic                  start,
    frame_capture_ctrl_if.slave   bus,
    output logic                  write_done,
    output logic                  read_done,
    output logic                  busy,
    output logic                  err_oob,
    output logic [15:0]           frame_count
);
`ifdef FRAME_CAPTURE_GRAY_EN
    localparam int STORE_W = PIX_W;
`else
    localparam int STORE_W = CHANNELS * PIX_W;
`endif
    localparam int DEPTH  = WIDTH * HEIGHT;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CAPTURE,
        READOUT,
        DONE
    } state_t;

    state_t               state_q;
    logic [STORE_W-1:0]   mem [DEPTH];
    logic [STORE_W-1:0]   ramData_q;
    logic [STORE_W-1:0]   storeWord_d;
    logic [ADDR_W-1:0]    wrAddr_d;
    logic [ADDR_W-1:0]    ramAddr_d;
    logic [ADDR_W-1:0]    fetchAddr_q;
    logic                 inRange_d;
    logic                 isLast_d;
    logic                 armHit_d;
    logic                 writeEn_d;
    logic                 advance_d;
    logic                 outLast_d;
    logic                 primed_q;
    logic                 outValid_q;
    logic [STORE_W-1:0]   outPix_q;
    logic [COORD_W-1:0]   outX_q;
    logic [COORD_W-1:0]   outY_q;
    logic                 writeDone_q;
    logic                 readDone_q;
    logic                 errOob_q;
    logic                 busy_q;
    logic [15:0]          frameCount_q;

`ifdef FRAME_CAPTURE_GRAY_EN
    logic [PIX_W+1:0]     graySum_d;

    always_comb begin
        graySum_d   = (PIX_W+2)'(bus.in_pix[0 +: PIX_W])
                    + ((PIX_W+2)'(bus.in_pix[PIX_W +: PIX_W]) << 1)
                    + (PIX_W+2)'(bus.in_pix[2*PIX_W +: PIX_W]);
        storeWord_d = graySum_d[PIX_W+1:2];
    end
`else
    assign storeWord_d = bus.in_pix;
`endif

    // fetchAddr_q names the word sitting in ramData_q, one ahead of the output register,
    // so a stall simply re-reads the same address and an accept moves both forward.
    always_comb begin
        inRange_d = (32'(bus.in_x) < WIDTH) && (32'(bus.in_y) < HEIGHT);
        wrAddr_d  = ADDR_W'(32'(bus.in_y) * WIDTH + 32'(bus.in_x));
        isLast_d  = (bus.in_x == COORD_W'(WIDTH - 1)) && (bus.in_y == COORD_W'(HEIGHT - 1));
        armHit_d  = (state_q == ARM) && bus.in_valid && (bus.in_x == '0) && (bus.in_y == '0);
        writeEn_d = !rst && bus.in_valid && inRange_d && ((state_q == CAPTURE) || armHit_d);
        outLast_d = (outX_q == COORD_W'(WIDTH - 1)) && (outY_q == COORD_W'(HEIGHT - 1));
        advance_d = (state_q == READOUT) && primed_q && (outValid_q ? bus.out_ready : 1'b1);
        ramAddr_d = fetchAddr_q;
        if (advance_d && (fetchAddr_q != ADDR_W'(DEPTH - 1))) begin
            ramAddr_d = fetchAddr_q + 1'b1;
        end
    end

    always_ff @(posedge CAMERA_CLK) begin
        if (writeEn_d) begin
            mem[wrAddr_d] <= storeWord_d;
        end
        ramData_q <= mem[ramAddr_d];
    end

    always_ff @(posedge CAMERA_CLK) begin
        if (rst) begin
            state_q      <= IDLE;
            fetchAddr_q  <= '0;
            primed_q     <= 1'b0;
            outValid_q   <= 1'b0;
            outPix_q     <= '0;
            outX_q       <= '0;
            outY_q       <= '0;
            writeDone_q  <= 1'b0;
            readDone_q   <= 1'b0;
            errOob_q     <= 1'b0;
            busy_q       <= 1'b0;
            frameCount_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= ARM;
                        busy_q      <= 1'b1;
                        writeDone_q <= 1'b0;
                        readDone_q  <= 1'b0;
                        errOob_q    <= 1'b0;
                    end
                end
                ARM: begin
                    if (armHit_d) begin
                        if (isLast_d) begin
                            state_q     <= READOUT;
                            writeDone_q <= 1'b1;
                            fetchAddr_q <= '0;
                            primed_q    <= 1'b0;
                        end else begin
                            state_q <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (bus.in_valid) begin
                        if (!inRange_d) begin
                            errOob_q <= 1'b1;
                        end else if (isLast_d) begin
                            state_q     <= READOUT;
                            writeDone_q <= 1'b1;
                            fetchAddr_q <= '0;
                            primed_q    <= 1'b0;
                        end
                    end
                end
                // First cycle primes the RAM, second loads the output register.
                READOUT: begin
                    fetchAddr_q <= ramAddr_d;
                    if (!primed_q) begin
                        primed_q <= 1'b1;
                    end else if (!outValid_q) begin
                        outValid_q <= 1'b1;
                        outPix_q   <= ramData_q;
                        outX_q     <= '0;
                        outY_q     <= '0;
                    end else if (bus.out_ready) begin
                        if (outLast_d) begin
                            outValid_q   <= 1'b0;
                            readDone_q   <= 1'b1;
                            frameCount_q <= frameCount_q + 16'd1;
                            busy_q       <= 1'b0;
                            state_q      <= DONE;
                        end else begin
                            outPix_q <= ramData_q;
                            if (outX_q == COORD_W'(WIDTH - 1)) begin
                                outX_q <= '0;
                                outY_q <= outY_q + 1'b1;
                            end else begin
                                outX_q <= outX_q + 1'b1;
                            end
                        end
                    end
                end
                // Automatic re-arm behaves like a fresh start so the flags describe the new frame.
                DONE: begin
                    if (start || (CONTINUOUS != 0)) begin
                        state_q     <= ARM;
                        busy_q      <= 1'b1;
                        writeDone_q <= 1'b0;
                        readDone_q  <= 1'b0;
                        errOob_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.out_pix   = outPix_q;
    assign bus.out_x     = outX_q;
    assign bus.out_y     = outY_q;
    assign write_done    = writeDone_q;
    assign read_done     = readDone_q;
    assign busy          = busy_q;
    assign err_oob       = errOob_q;
    assign frame_count   = frameCount_q;
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Self-checking bench for frame_capture_ctrl on a 4x2 frame with a readout scoreboard.
module tb_frame_capture_ctrl;
    localparam int WIDTH    = 4;
    localparam int HEIGHT   = 2;
    localparam int PIX_W    = 8;
    localparam int CHANNELS = 3;
    localparam int COORD_W  = 11;
    localparam int NPIX     = WIDTH * HEIGHT;
`ifdef FRAME_CAPTURE_GRAY_EN
    localparam int STORE_W = PIX_W;
`else
    localparam int STORE_W = CHANNELS * PIX_W;
`endif

    typedef struct {
        logic [STORE_W-1:0] pix;
        int                 x;
        int                 y;
    } sbEntry_t;

    logic        CAMERA_CLK;
    logic        rst;
    logic        start;
    logic        write_done;
    logic        read_done;
    logic        busy;
    logic        err_oob;
    logic [15:0] frame_count;

    int          checks;
    int          failures;
    int          readyMode;
    int          readyPhase;
    sbEntry_t    sbQueue[$];
    sbEntry_t    sbExp;
    logic        stallPrev;
    logic [STORE_W-1:0] heldPix;
    logic [COORD_W-1:0] heldX;
    logic [COORD_W-1:0] heldY;

    frame_capture_ctrl_if #(.PIX_W(PIX_W), .CHANNELS(CHANNELS), .COORD_W(COORD_W)) bus ();

    frame_capture_ctrl #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIX_W(PIX_W), .CHANNELS(CHANNELS),
        .COORD_W(COORD_W), .CONTINUOUS(0)
    ) dut (
        .CAMERA_CLK (CAMERA_CLK),
        .rst        (rst),
        .start      (start),
        .bus        (bus.slave),
        .write_done (write_done),
        .read_done  (read_done),
        .busy       (busy),
        .err_oob    (err_oob),
        .frame_count(frame_count)
    );

    initial CAMERA_CLK = 1'b0;
    always #5 CAMERA_CLK = ~CAMERA_CLK;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [STORE_W-1:0] expectedStore(input logic [23:0] p);
`ifdef FRAME_CAPTURE_GRAY_EN
        int s;
        s = int'(p[7:0]) + 2 * int'(p[15:8]) + int'(p[23:16]);
        return STORE_W'(s >> 2);
`else
        return STORE_W'(p);
`endif
    endfunction

    task automatic applyStimulus(input int x, input int y, input logic [23:0] pix);
        bus.in_valid = 1'b1;
        bus.in_x     = COORD_W'(x);
        bus.in_y     = COORD_W'(y);
        bus.in_pix   = pix;
        @(posedge CAMERA_CLK);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge CAMERA_CLK);
        #1;
        start = 1'b0;
    endtask

    // style 0: pixel value = index; 1: gray vectors then random; 2: like 1 with an out-of-range pixel
    task automatic sendFrame(input int style);
        logic [23:0] p;
        sbEntry_t    e;
        for (int i = 0; i < NPIX; i++) begin
            if (style == 0) p = 24'(i);
            else if (i == 0) p = 24'h302010;
            else if (i == 1) p = 24'hFFFFFF;
            else p = 24'($urandom);
            if (style == 2 && i == 6) begin
                checkOutput("errOobBefore", err_oob, 0);
                applyStimulus(5, 0, 24'hABCDEF);
                checkOutput("errOobSet", err_oob, 1);
            end
            if (i == NPIX - 1) checkOutput("wdoneBeforeLast", write_done, 0);
            e.pix = expectedStore(p);
            e.x   = i % WIDTH;
            e.y   = i / WIDTH;
            sbQueue.push_back(e);
            applyStimulus(i % WIDTH, i / WIDTH, p);
        end
        checkOutput("wdoneAfterLast", write_done, 1);
    endtask

    task automatic waitReadDone(input string tag);
        int n;
        n = 0;
        while (!read_done && n < 500) begin
            @(posedge CAMERA_CLK);
            #1;
            n++;
        end
        checkOutput(tag, read_done, 1);
        checkOutput("sbDrained", sbQueue.size(), 0);
        checkOutput("busyDone", busy, 0);
        checkOutput("validDone", bus.out_valid, 0);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        readyPhase    = 0;
        forever begin
            @(posedge CAMERA_CLK);
            #1;
            case (readyMode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (readyPhase == 0) || (readyPhase == 3);
                default: bus.out_ready = 1'b0;
            endcase
            readyPhase = (readyPhase + 1) % 4;
        end
    end

    // Scoreboard consumer plus hold-while-stalled check on the readout stream.
    always @(negedge CAMERA_CLK) begin
        if (rst) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("holdValid", bus.out_valid, 1);
                checkOutput("holdPix", bus.out_pix, heldPix);
                checkOutput("holdXY", {bus.out_x, bus.out_y}, {heldX, heldY});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("sbUnderflow", 1, 0);
                end else begin
                    sbExp = sbQueue.pop_front();
                    checkOutput("outPix", bus.out_pix, sbExp.pix);
                    checkOutput("outX", bus.out_x, sbExp.x);
                    checkOutput("outY", bus.out_y, sbExp.y);
                end
            end
            stallPrev = bus.out_valid && !bus.out_ready;
            heldPix   = bus.out_pix;
            heldX     = bus.out_x;
            heldY     = bus.out_y;
        end
    end

    initial begin
        int n;
        checks       = 0;
        failures     = 0;
        readyMode    = 0;
        stallPrev    = 1'b0;
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.in_pix   = '0;
        repeat (3) @(posedge CAMERA_CLK);
        #1;
        rst = 1'b0;
        checkOutput("rstValid", bus.out_valid, 0);
        checkOutput("rstPix", bus.out_pix, 0);
        checkOutput("rstXY", {bus.out_x, bus.out_y}, 0);
        checkOutput("rstFlags", {write_done, read_done, busy, err_oob}, 0);
        checkOutput("rstCount", frame_count, 0);

        // Pixels in IDLE are ignored
        applyStimulus(0, 0, 24'h111111);
        applyStimulus(3, 1, 24'h222222);
        checkOutput("idleBusy", busy, 0);
        checkOutput("idleWdone", write_done, 0);

        // Full frame, latency of first out_valid
        pulseStart();
        checkOutput("armBusy", busy, 1);
        sendFrame(0);
        checkOutput("lat0", bus.out_valid, 0);
        @(posedge CAMERA_CLK); #1;
        checkOutput("lat1", bus.out_valid, 0);
        @(posedge CAMERA_CLK); #1;
        checkOutput("lat2", bus.out_valid, 1);
        waitReadDone("frameA");
        checkOutput("countA", frame_count, 1);

        // Backpressure 1,0,0,1 during readout
        pulseStart();
        checkOutput("clearRdone", read_done, 0);
        checkOutput("clearWdone", write_done, 0);
        readyMode = 1;
        sendFrame(1);
        waitReadDone("frameB");
        checkOutput("countB", frame_count, 2);
        readyMode = 0;

        // Out-of-range pixel mid-capture
        pulseStart();
        sendFrame(2);
        waitReadDone("frameC");
        checkOutput("errOobHeld", err_oob, 1);
        checkOutput("countC", frame_count, 3);

        // Non-origin pixels while armed are ignored
        pulseStart();
        checkOutput("errOobCleared", err_oob, 0);
        applyStimulus(2, 0, 24'h333333);
        applyStimulus(3, 1, 24'h444444);
        repeat (2) @(posedge CAMERA_CLK);
        #1;
        checkOutput("armWdone", write_done, 0);
        checkOutput("armValid", bus.out_valid, 0);
        checkOutput("armBusy2", busy, 1);
        sendFrame(0);
        waitReadDone("frameD");
        checkOutput("countD", frame_count, 4);

        // Reset during a stalled readout
        readyMode = 2;
        pulseStart();
        sendFrame(1);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge CAMERA_CLK); #1;
            n++;
        end
        checkOutput("stallValid", bus.out_valid, 1);
        repeat (2) @(posedge CAMERA_CLK);
        #1;
        rst   = 1'b1;
        start = 1'b1;
        @(posedge CAMERA_CLK);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        sbQueue.delete();
        checkOutput("midRstValid", bus.out_valid, 0);
        checkOutput("midRstPix", bus.out_pix, 0);
        checkOutput("midRstXY", {bus.out_x, bus.out_y}, 0);
        checkOutput("midRstFlags", {write_done, read_done, busy, err_oob}, 0);
        checkOutput("midRstCount", frame_count, 0);
        readyMode = 0;
        applyStimulus(0, 0, 24'h555555);
        checkOutput("postRstIgnored", busy, 0);
        pulseStart();
        sendFrame(1);
        waitReadDone("frameE");
        checkOutput("countE", frame_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
